// File: rtl/nf10_timestamp_pkg.sv
// Shared constants for the receive-path timestamp stamper: timestamp width,
// default tuser field position and the skid-buffer state encoding.
package nf10_timestamp_pkg;

   localparam int unsigned TIMESTAMP_WIDTH      = 64;
   localparam int unsigned TS_TUSER_POS_DEFAULT = 64;

   localparam int unsigned SKID_STATE_W = 2;
   localparam logic [SKID_STATE_W-1:0] SKID_EMPTY = 2'd0;
   localparam logic [SKID_STATE_W-1:0] SKID_ONE   = 2'd1;
   localparam logic [SKID_STATE_W-1:0] SKID_FULL  = 2'd2;

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic two-entry registered stream slice: output register plus one skid
// register, with a registered ready that drops only while both are occupied.
module axis_skid_buffer
   import nf10_timestamp_pkg::*;
#(
   parameter int unsigned PAYLOAD_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [PAYLOAD_WIDTH-1:0] s_payload_i,
   input  logic                     s_valid_i,
   output logic                     s_ready_o,
   output logic [PAYLOAD_WIDTH-1:0] m_payload_o,
   output logic                     m_valid_o,
   input  logic                     m_ready_i
);

   logic [SKID_STATE_W-1:0]  state_q, state_d;
   logic [PAYLOAD_WIDTH-1:0] out_q, out_d;
   logic [PAYLOAD_WIDTH-1:0] skid_q, skid_d;
   logic                     m_valid_q, m_valid_d;
   logic                     s_ready_q, s_ready_d;
   logic                     in_acc;
   logic                     out_acc;

   assign in_acc  = s_valid_i & s_ready_q;
   assign out_acc = m_valid_q & m_ready_i;

   // Next-state and data steering; the skid entry is only touched when the
   // output register is occupied and not draining in the same cycle.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         SKID_EMPTY: begin
            if (in_acc) begin
               out_d   = s_payload_i;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (in_acc && out_acc) begin
               out_d = s_payload_i;
            end else if (in_acc) begin
               skid_d  = s_payload_i;
               state_d = SKID_FULL;
            end else if (out_acc) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (out_acc) begin
               out_d   = skid_q;
               state_d = SKID_ONE;
            end
         end
         default: begin
            state_d = SKID_EMPTY;
         end
      endcase
      m_valid_d = (state_d != SKID_EMPTY);
      s_ready_d = (state_d != SKID_FULL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SKID_EMPTY;
         out_q     <= '0;
         skid_q    <= '0;
         m_valid_q <= 1'b0;
         s_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         skid_q    <= skid_d;
         m_valid_q <= m_valid_d;
         s_ready_q <= s_ready_d;
      end
   end

   assign s_ready_o   = s_ready_q;
   assign m_payload_o = out_q;
   assign m_valid_o   = m_valid_q;

endmodule

// File: rtl/timestamp_stamper.sv
// Stamps the free-running timestamp into tuser on the first accepted beat of
// each AXI4-Stream packet and forwards the stream through a registered skid.
module timestamp_stamper
   import nf10_timestamp_pkg::*;
#(
   parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned TIMESTAMP_WIDTH    = nf10_timestamp_pkg::TIMESTAMP_WIDTH,
   parameter int unsigned TS_TUSER_POS       = TS_TUSER_POS_DEFAULT
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [TIMESTAMP_WIDTH-1:0]      stamp_counter,
   input  logic                            stamp_enable,
   input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                            s_axis_tvalid,
   input  logic                            s_axis_tlast,
   output logic                            s_axis_tready,
   output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                            m_axis_tvalid,
   output logic                            m_axis_tlast,
   input  logic                            m_axis_tready,
   output logic [31:0]                     pkt_count
);

   localparam int unsigned STRB_WIDTH    = C_AXIS_DATA_WIDTH / 8;
   localparam int unsigned PAYLOAD_WIDTH = C_AXIS_DATA_WIDTH + STRB_WIDTH
                                           + C_AXIS_TUSER_WIDTH + 1;

   logic                          in_pkt_q, in_pkt_d;
   logic [31:0]                   pkt_count_q, pkt_count_d;
   logic                          skid_ready;
   logic                          in_acc;
   logic                          sof;
   logic                          stamp_sof;
   logic [C_AXIS_TUSER_WIDTH-1:0] tuser_merged;
   logic [PAYLOAD_WIDTH-1:0]      skid_in;
   logic [PAYLOAD_WIDTH-1:0]      skid_out;

   assign in_acc    = s_axis_tvalid & skid_ready;
   assign sof       = ~in_pkt_q;
   assign stamp_sof = sof & stamp_enable;

   // The merge sits in front of the skid so the stamp is the counter at the
   // input accept edge, regardless of how long the beat waits downstream.
   always_comb begin
      tuser_merged = s_axis_tuser;
      if (stamp_sof) begin
         tuser_merged[TS_TUSER_POS +: TIMESTAMP_WIDTH] = stamp_counter;
      end
   end

   always_comb begin
      in_pkt_d    = in_pkt_q;
      pkt_count_d = pkt_count_q;
      if (in_acc) begin
         in_pkt_d = ~s_axis_tlast;
         if (stamp_sof) begin
            pkt_count_d = pkt_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_pkt_q    <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         in_pkt_q    <= in_pkt_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign skid_in = {s_axis_tdata, s_axis_tstrb, tuser_merged, s_axis_tlast};

   axis_skid_buffer #(
      .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
   ) u_skid (
      .clk         (clk),
      .reset       (reset),
      .s_payload_i (skid_in),
      .s_valid_i   (s_axis_tvalid),
      .s_ready_o   (skid_ready),
      .m_payload_o (skid_out),
      .m_valid_o   (m_axis_tvalid),
      .m_ready_i   (m_axis_tready)
   );

   assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = skid_out;
   assign s_axis_tready = skid_ready;
   assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_timestamp_stamper.sv
// Self-checking bench for timestamp_stamper: directed scenarios plus random
// traffic, compared against a queue-based model of the stamped stream.
module tb_timestamp_stamper;

   localparam int unsigned DW = 256;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned UW = 128;
   localparam int unsigned TW = 64;
   localparam int unsigned TP = 64;
   localparam int unsigned CW = 512;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic [UW-1:0] u;
      logic          l;
   } beat_t;

   logic          clk;
   logic          reset;
   logic [TW-1:0] stamp_counter;
   logic          stamp_enable;
   logic [DW-1:0] s_tdata;
   logic [SW-1:0] s_tstrb;
   logic [UW-1:0] s_tuser;
   logic          s_tvalid;
   logic          s_tlast;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic [SW-1:0] m_tstrb;
   logic [UW-1:0] m_tuser;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready;
   logic [31:0]   pkt_count;

   timestamp_stamper #(
      .C_AXIS_DATA_WIDTH  (DW),
      .C_AXIS_TUSER_WIDTH (UW),
      .TIMESTAMP_WIDTH    (TW),
      .TS_TUSER_POS       (TP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stamp_counter (stamp_counter),
      .stamp_enable  (stamp_enable),
      .s_axis_tdata  (s_tdata),
      .s_axis_tstrb  (s_tstrb),
      .s_axis_tuser  (s_tuser),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tstrb  (m_tstrb),
      .m_axis_tuser  (m_tuser),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .pkt_count     (pkt_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // Reference model state
   beat_t       exp_q[$];
   bit          m_inpkt;
   logic [31:0] m_cnt;
   bit          m_after_reset;
   bit          hold_pending;
   beat_t       held;
   int          beats_left;
   int          pkt_len;
   logic [TW-1:0] cnt_step;
   bit          rand_en;

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [UW-1:0] rnd_user();
      logic [UW-1:0] r;
      for (int i = 0; i < int'(UW / 32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic beat_t cur_out();
      beat_t b;
      b = {m_tdata, m_tstrb, m_tuser, m_tlast};
      return b;
   endfunction

   // One clock: check observables at the negedge, update model, advance.
   task automatic cycle();
      bit    exp_valid, exp_ready, in_acc, out_acc;
      beat_t b, e;
      exp_valid = (exp_q.size() != 0);
      exp_ready = !m_after_reset && (exp_q.size() < 2);
      chk("s_axis_tready", CW'(s_tready), CW'(exp_ready));
      chk("m_axis_tvalid", CW'(m_tvalid), CW'(exp_valid));
      chk("pkt_count", CW'(pkt_count), CW'(m_cnt));
      if (hold_pending) chk("stall_stable", CW'(cur_out()), CW'(held));
      out_acc = exp_valid && m_tready;
      in_acc  = s_tvalid && exp_ready;
      if (out_acc) begin
         e = exp_q.pop_front();
         chk("out_beat", CW'(cur_out()), CW'(e));
      end
      hold_pending = exp_valid && !m_tready;
      held         = cur_out();
      if (in_acc) begin
         b = {s_tdata, s_tstrb, s_tuser, s_tlast};
         if (!m_inpkt && stamp_enable) begin
            b.u[TP +: TW] = stamp_counter;
            m_cnt = m_cnt + 32'd1;
         end
         m_inpkt = !s_tlast;
         exp_q.push_back(b);
         beats_left--;
      end
      m_after_reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      stamp_counter = stamp_counter + cnt_step;
      if (in_acc) s_tvalid = 1'b0;
   endtask

   task automatic next_beat();
      if (beats_left <= 0) beats_left = (pkt_len > 0) ? pkt_len : int'($urandom_range(1, 5));
      s_tdata  = rnd_data();
      s_tstrb  = SW'($urandom);
      s_tuser  = rnd_user();
      s_tlast  = (beats_left == 1);
      s_tvalid = 1'b1;
   endtask

   task automatic run(input int n, input int vprob, input int rprob);
      for (int i = 0; i < n; i++) begin
         if (!s_tvalid && int'($urandom_range(0, 99)) < vprob) next_beat();
         m_tready = (int'($urandom_range(0, 99)) < rprob);
         if (rand_en) stamp_enable = ($urandom_range(0, 3) != 0);
         cycle();
      end
   endtask

   task automatic finish_pkt();
      for (int i = 0; i < 100; i++) begin
         if (beats_left <= 0 && !s_tvalid) break;
         run(1, 100, 100);
      end
      chk("pkt_finish_bound", CW'(beats_left <= 0 && !s_tvalid), CW'(1));
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      s_tvalid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", CW'(m_tvalid), CW'(0));
      chk("rst_m_tdata", CW'(m_tdata), CW'(0));
      chk("rst_m_tuser", CW'(m_tuser), CW'(0));
      chk("rst_m_tlast", CW'(m_tlast), CW'(0));
      chk("rst_s_tready", CW'(s_tready), CW'(0));
      chk("rst_pkt_count", CW'(pkt_count), CW'(0));
      reset = 1'b0;
      exp_q.delete();
      m_inpkt       = 1'b0;
      m_cnt         = '0;
      m_after_reset = 1'b1;
      hold_pending  = 1'b0;
      beats_left    = 0;
   endtask

   initial begin
      logic [UW-1:0] sent_user;
      logic [31:0]   c0;
      reset = 1'b1; stamp_counter = '0; stamp_enable = 1'b1;
      s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      m_tready = 1'b0; cnt_step = 64'd32; rand_en = 1'b0; pkt_len = 1;
      m_inpkt = 1'b0; m_cnt = '0; m_after_reset = 1'b1; hold_pending = 1'b0;
      held = '0; beats_left = 0;
      @(negedge clk);
      do_reset();
      run(1, 0, 100);

      // Single-beat packet
      stamp_counter = 64'h0000_0001_0000_0020;
      pkt_len = 1;
      next_beat();
      sent_user = s_tuser;
      run(1, 100, 100);
      chk("single_valid", CW'(m_tvalid), CW'(1));
      chk("single_ts", CW'(m_tuser[127:64]), CW'(64'h0000_0001_0000_0020));
      chk("single_low_user", CW'(m_tuser[63:0]), CW'(sent_user[63:0]));
      run(1, 0, 100);
      chk("single_count", CW'(pkt_count), CW'(1));

      // 4-beat packet starting at counter 0x1000
      stamp_counter = 64'h1000;
      pkt_len = 4;
      run(4, 100, 100);
      run(2, 0, 100);

      // Backpressure mid-packet
      pkt_len = 6;
      run(1, 100, 100);
      run(10, 100, 0);
      chk("bp_ready_low", CW'(s_tready), CW'(0));
      run(12, 100, 100);
      finish_pkt();

      // Enable low on SOF, raised mid-packet
      c0 = m_cnt;
      stamp_enable = 1'b0;
      pkt_len = 4;
      run(2, 100, 100);
      stamp_enable = 1'b1;
      finish_pkt();
      chk("en0_count_hold", CW'(pkt_count), CW'(c0));
      pkt_len = 2;
      run(1, 100, 100);
      finish_pkt();
      chk("en1_count_inc", CW'(pkt_count), CW'(c0 + 32'd1));
      run(2, 0, 100);

      // Reset with a full buffer mid-packet
      pkt_len = 8;
      run(1, 100, 100);
      run(4, 100, 0);
      do_reset();
      pkt_len = 3;
      run(1, 0, 100);
      run(1, 100, 100);
      chk("post_reset_sof", CW'(pkt_count), CW'(1));
      finish_pkt();
      run(2, 0, 100);

      // Packet counter wrap
      force dut.pkt_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.pkt_count_q;
      m_cnt = 32'hFFFF_FFFF;
      chk("preload_count", CW'(pkt_count), CW'(32'hFFFF_FFFF));
      pkt_len = 1;
      run(1, 100, 100);
      chk("wrap_count", CW'(pkt_count), CW'(0));
      run(2, 0, 100);

      // Random traffic with random enable and backpressure
      pkt_len = 0;
      rand_en = 1'b1;
      cnt_step = 64'd1 + 64'($urandom_range(0, 100));
      run(600, 70, 70);
      rand_en = 1'b0;
      stamp_enable = 1'b1;
      finish_pkt();
      run(4, 0, 100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/timestamp_stamper.md
# timestamp_stamper

Receive-path stage directly downstream of `stamp_counter`. It samples the free-running 64-bit timestamp on the accepted first beat of each AXI4-Stream packet and writes that timestamp into a fixed `tuser` field of the same beat. It forwards the stream through a two-entry registered skid buffer, so backpressure never corrupts or re-samples a stamp. It sits between the MAC RX interface and the input arbiter, one instance per port.

## Interface

Parameters:
- `C_AXIS_DATA_WIDTH`, default 256: `tdata` width; `tstrb` width is `C_AXIS_DATA_WIDTH/8`.
- `C_AXIS_TUSER_WIDTH`, default 128: `tuser` width.
- `TIMESTAMP_WIDTH`, default 64: width of `stamp_counter`.
- `TS_TUSER_POS`, default 64: LSB position of the timestamp field in `tuser`. `TS_TUSER_POS + TIMESTAMP_WIDTH <= C_AXIS_TUSER_WIDTH` is required.

Ports:
- `clk` in 1: the single clock, same as the timestamp counter.
- `reset` in 1: synchronous, active-high.
- `stamp_counter` in `TIMESTAMP_WIDTH`: current time, driven by `stamp_counter`.
- `stamp_enable` in 1: 1 = overwrite the `tuser` field; 0 = pass `tuser` through unchanged.
- `s_axis_tdata`, `s_axis_tstrb`, `s_axis_tuser`, `s_axis_tvalid`, `s_axis_tlast` in: slave stream.
- `s_axis_tready` out 1: registered ready.
- `m_axis_tdata`, `m_axis_tstrb`, `m_axis_tuser`, `m_axis_tvalid`, `m_axis_tlast` out: master stream, all registered.
- `m_axis_tready` in 1: downstream ready.
- `pkt_count` out 32: number of packets stamped (SOF beats accepted while enabled). Wraps at 2^32.

## Operation

- Input accept: `s_axis_tvalid & s_axis_tready`.
- Output accept: `m_axis_tvalid & m_axis_tready`.
- SOF tracking: `in_pkt` flag, reset 0.
  - Set on an accepted beat with `tlast`=0.
  - Cleared on an accepted beat with `tlast`=1.
  - An accepted beat is SOF when `in_pkt`=0.
- Stamping, on an SOF beat:
  - `stamp_enable` is sampled in the same cycle as the SOF beat.
  - If enabled, `tuser[TS_TUSER_POS +: TIMESTAMP_WIDTH]` is replaced with the `stamp_counter` value present in the accept cycle; all other `tuser` bits are unchanged.
  - Non-SOF beats are never modified.
  - A single-beat packet (SOF with `tlast`=1) is stamped, and the next beat is SOF.
- `stamp_enable` changes mid-packet take effect at the next SOF.
- Skid buffer FSM:
  - EMPTY: output register invalid. An input accept loads the output register → ONE.
  - ONE: output valid. Input only → skid loaded → FULL. Output only → EMPTY. Both → output reloaded, stay ONE.
  - FULL: output and skid valid, `s_axis_tready`=0. Output accept → skid moves to output → ONE.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- `pkt_count` increments by 1 per stamped SOF accept, +1 modulo 2^32.
- Time discontinuities are not filtered: values from `restart_time` reloads or from 0 resets are stamped as-is.
- Reset:
  - Output registers: all `m_axis_*`=0, `s_axis_tready`=0, `pkt_count`=0, `in_pkt`=0, FSM=EMPTY.
  - Reset mid-packet discards both buffered beats. The first beat accepted after reset is treated as SOF.
  - `s_axis_tready` goes to 1 in the first cycle after `reset` deasserts.

## Timing

- Latency: an input beat accepted in cycle N is presented on `m_axis` in cycle N+1 if the buffer was EMPTY, or after the held beats drain otherwise.
- The timestamp is the counter value at the input accept edge, not at output. Stamp-to-accept skew is 0 cycles and is independent of backpressure.
- `s_axis_tready` is a register: it deasserts the cycle after FULL is entered and reasserts the cycle after an output accept in FULL.
- Throughput: one beat/cycle sustained when `m_axis_tready`=1.
- `m_axis_*` must stay stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.

## Structure

- Shared package `nf10_timestamp_pkg`:
  - `TIMESTAMP_WIDTH`
  - default `TS_TUSER_POS`
  - skid-state encoding `{EMPTY, ONE, FULL}`, 2 bits
- Sub-module `axis_skid_buffer`: generic two-entry registered slice over `{tdata, tstrb, tuser, tlast}`.
- The top level holds SOF tracking, the `tuser` merge in front of the skid input, and `pkt_count`.

## Test plan

- Single-beat packet, `stamp_counter`=64'h0000_0001_0000_0020, enable=1, `m_axis_tready`=1 → output one cycle later with `tuser[127:64]`=64'h0000_0001_0000_0020, `tuser[63:0]` unchanged, `pkt_count`=1.
- 4-beat packet, counter incrementing by 32 per cycle, first beat accepted at counter 0x1000 → only beat 0 carries 0x1000; beats 1–3 have original `tuser`.
- Hold `m_axis_tready`=0 for 10 cycles mid-packet → `s_axis_tready` falls after 2 beats are buffered. Output is stable, and stamp values equal the counter at input accept, not at release.
- `stamp_enable`=0 on SOF, toggled to 1 mid-packet → packet passes unmodified, next packet is stamped, `pkt_count` unchanged for the first packet.
- Assert `reset` with FULL buffer mid-packet → outputs 0 the next cycle. After release, the first new beat (`tlast`=0) is stamped as SOF.
- Preload `pkt_count` near wrap via 2^32−1 stamped packets (or force) → next SOF gives `pkt_count`=0.
